gap_cell_pipe: RTL and testbench
================================

// Module: gap_cell_pipe
// PURPOSE
// Pipelined, parametrised single-gap recurrence cell for the 3-sequence (x,y,z) DP aligner.
// One instance per gap direction (DIR) computes that direction's gap score from the 7
// predecessor scores, with gap-penalty subtraction, saturation and a traceback pointer.
// Sits between the DP wavefront scheduler and the score/traceback memories.
// Uses valid/ready flow control.
// PARAMETERS
// W    12  score width; signed two's complement; NEG_INF = -2^(W-1)
// G0   2   gap-open penalty, >=0; 2*G0 < 2^(W-2)
// GE   1   gap-extend penalty, >=0; 2*GE < 2^(W-2)
// DIR  1   gap direction: 0=x, 1=y, 2=z
// PORTS
// clk        in   1    clock, rising edge
// rst_n      in   1    asynchronous active-low reset
// in_valid   in   1    input bundle valid
// in_ready   out  1    cell can accept bundle this cycle
// in_m       in   W    M predecessor score
// in_ixy     in   W    Ixy predecessor score
// in_iyz     in   W    Iyz predecessor score
// in_ixz     in   W    Ixz predecessor score
// in_ix      in   W    Ix predecessor score
// in_iy      in   W    Iy predecessor score
// in_iz      in   W    Iz predecessor score
// out_valid  out  1    result valid
// out_ready  in   1    downstream accepts result
// out_score  out  W    max of penalised predecessors
// out_ptr    out  3    index of winning predecessor, 0..6 = m,ixy,iyz,ixz,ix,iy,iz
// BEHAVIOUR
// - Reset (async, rst_n=0): all stage valids=0; out_valid=0; out_score=NEG_INF; out_ptr=0.
//   Reset mid-operation discards all in-flight bundles; nothing is emitted after release.
// - Penalty per index, d=DIR:
//   m -> 2*G0
//   pair gap containing d -> G0+GE
//   pair gap not containing d -> 2*G0
//   single gap == d -> 2*GE
//   other single gaps -> G0+GE
//   DIR=1: m 4, ixy 3, iyz 3, ixz 4, ix 3, iy 2, iz 3.
// - Stage 1 (S1): subtract in W+2 bits and clamp to >= NEG_INF. NEG_INF input stays NEG_INF.
//   Register 7 scores.
// - Stage 2 (S2): pairwise max (0,1), (2,3), (4,5); 6 passes through. Register 4 scores + 4 ptrs.
// - Stage 3 (S3): max over the 4 candidates. Register out_score and out_ptr.
// - Ties at every comparison: lower index wins, so out_ptr is the lowest index of the max.
// - Latency 3 cycles from accepted input to out_valid with out_ready held high.
//   Throughput 1 bundle/cycle.
// - Flow control:
//   ld3 = !v3 || out_ready;  ld2 = !v2 || ld3;  ld1 = !v1 || ld2;  in_ready = ld1.
//   Transfer occurs when in_valid && in_ready. A stage with its ld low holds its data.
//   Max 3 bundles in flight.
// - out_score/out_ptr stay stable while out_valid && !out_ready.
// - Bundles emerge in acceptance order, with no loss and no duplication.
// - Simultaneous accept and emit with the pipe full: allowed; occupancy unchanged.
// TESTING (W=12, G0=2, GE=1, DIR=1 unless noted)
// 1. in_m=10, others=-2048 -> after 3 cycles out_score=6, out_ptr=0.
// 2. Tie: in_m=7, in_iy=5, others=-2048 -> out_score=3, out_ptr=0.
//    Same with in_m=6 -> out_score=3, out_ptr=5.
// 3. Saturation: all inputs=-2046 -> out_score=-2048 (clamped), out_ptr=0, no wrap to positive.
// 4. Backpressure: stream 5 bundles, out_ready=0 for 6 cycles.
//    -> exactly 3 accepted, in_ready=0 thereafter, outputs stable.
//    Release -> all 5 emitted in order.
// 5. DIR=0: in_ix=9, in_iyz=10, others=-2048 -> cand ix=7, iyz=6 -> out_score=7, out_ptr=4.
// 6. Assert rst_n=0 with 2 bundles in flight -> out_valid=0 immediately.
//    After release, no stale output; next bundle has latency 3.

Source files
------------

// File: rtl/gap_cell_pipe.sv
// gap_cell_pipe: pipelined single-gap recurrence cell for the 3-sequence
// (x,y,z) DP aligner. One instance per gap direction DIR computes that
// direction's gap score from the seven predecessor scores (m, ixy, iyz, ixz,
// ix, iy, iz). Each predecessor has a direction-dependent penalty subtracted
// and is clamped at NEG_INF. The largest result is returned together with the
// index of its predecessor (out_ptr).
//
// Pipeline: S1 penalise+clamp -> S2 pairwise max -> S3 final max (3 cycles).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    input bundle handshake
//   in_m .. in_iz        seven signed W-bit predecessor scores
//   out_valid/out_ready  result handshake
//   out_score            max of penalised predecessors (signed W bits)
//   out_ptr              winning predecessor, 0..6 = m,ixy,iyz,ixz,ix,iy,iz
//
// Handshake: a bundle moves across a boundary on a clock edge where valid and
// ready are both high. A producer holds valid and its data stable until that
// edge. Each stage loads when it is empty or its successor is loading, so the
// pipe holds up to 3 bundles and streams one per cycle under out_ready=1.
module gap_cell_pipe #(
    parameter int W   = 12,
    parameter int G0  = 2,
    parameter int GE  = 1,
    parameter int DIR = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_m,
    input  logic signed [W-1:0] in_ixy,
    input  logic signed [W-1:0] in_iyz,
    input  logic signed [W-1:0] in_ixz,
    input  logic signed [W-1:0] in_ix,
    input  logic signed [W-1:0] in_iy,
    input  logic signed [W-1:0] in_iz,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_score,
    output logic [2:0]          out_ptr
);

    localparam logic signed [W-1:0] NEG_INF     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W+1:0] NEG_INF_EXT = {3'b111, {(W-1){1'b0}}};

    // Gap penalty per predecessor index for this cell's direction.
    // Pair gaps: ixy={x,y}, iyz={y,z}, ixz={x,z}; singles ix, iy, iz.
    function automatic logic signed [W+1:0] pen_of(input int idx);
        int p;
        case (idx)
            0:       p = 2 * G0;
            1:       p = (DIR == 0 || DIR == 1) ? G0 + GE : 2 * G0;
            2:       p = (DIR == 1 || DIR == 2) ? G0 + GE : 2 * G0;
            3:       p = (DIR == 0 || DIR == 2) ? G0 + GE : 2 * G0;
            4:       p = (DIR == 0) ? 2 * GE : G0 + GE;
            5:       p = (DIR == 1) ? 2 * GE : G0 + GE;
            default: p = (DIR == 2) ? 2 * GE : G0 + GE;
        endcase
        return p[W+1:0];
    endfunction

    logic                ld1, ld2, ld3;
    logic                v1, v2;
    logic signed [W-1:0] in_s [7];
    logic signed [W+1:0] ext  [7];
    logic signed [W+1:0] diff [7];
    logic signed [W-1:0] s1_n [7];
    logic signed [W-1:0] s1   [7];
    logic signed [W-1:0] s2_n [4];
    logic [2:0]          p2_n [4];
    logic signed [W-1:0] s2   [4];
    logic [2:0]          p2   [4];
    logic signed [W-1:0] best;
    logic [2:0]          best_ptr;

    // Backward load chain: a stage may load if empty or its successor loads.
    assign ld3      = !out_valid || out_ready;
    assign ld2      = !v2 || ld3;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;

    // S1: subtract in W+2 bits so nothing wraps, then clamp at NEG_INF.
    always_comb begin
        in_s[0] = in_m;
        in_s[1] = in_ixy;
        in_s[2] = in_iyz;
        in_s[3] = in_ixz;
        in_s[4] = in_ix;
        in_s[5] = in_iy;
        in_s[6] = in_iz;
        for (int i = 0; i < 7; i++) begin
            ext[i]  = {{2{in_s[i][W-1]}}, in_s[i]};
            diff[i] = ext[i] - pen_of(i);
            if (in_s[i] == NEG_INF || diff[i] < NEG_INF_EXT)
                s1_n[i] = NEG_INF;
            else
                s1_n[i] = diff[i][W-1:0];
        end
    end

    // S2: pairwise max; '>=' keeps the lower index on ties.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            if (s1[2*k] >= s1[2*k+1]) begin
                s2_n[k] = s1[2*k];
                p2_n[k] = 3'(2 * k);
            end else begin
                s2_n[k] = s1[2*k+1];
                p2_n[k] = 3'(2 * k + 1);
            end
        end
        s2_n[3] = s1[6];
        p2_n[3] = 3'd6;
    end

    // S3: candidates are ordered by index, so strict '>' keeps the lowest.
    always_comb begin
        best     = s2[0];
        best_ptr = p2[0];
        for (int k = 1; k < 4; k++) begin
            if (s2[k] > best) begin
                best     = s2[k];
                best_ptr = p2[k];
            end
        end
    end

    // Data registers only load with a valid bundle, so outputs keep their
    // last (or reset) value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_score <= NEG_INF;
            out_ptr   <= 3'd0;
            for (int i = 0; i < 7; i++) s1[i] <= NEG_INF;
            for (int k = 0; k < 4; k++) begin
                s2[k] <= NEG_INF;
                p2[k] <= 3'd0;
            end
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) s1 <= s1_n;
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    s2 <= s2_n;
                    p2 <= p2_n;
                end
            end
            if (ld3) begin
                out_valid <= v2;
                if (v2) begin
                    out_score <= best;
                    out_ptr   <= best_ptr;
                end
            end
        end
    end

endmodule

// File: tb/tb_gap_cell_pipe.sv
// Directed bench for gap_cell_pipe. Two instances share all inputs: dut
// (DIR=1) and dut0 (DIR=0). Inputs change on the falling edge, outputs are
// read on the falling edge.
module tb_gap_cell_pipe;

  localparam int W = 12;
  localparam logic signed [W-1:0] NI = 12'sh800;  // -2048

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                out_ready;
  logic signed [W-1:0] in_m, in_ixy, in_iyz, in_ixz, in_ix, in_iy, in_iz;
  logic                in_ready, in_ready0;
  logic                out_valid, out_valid0;
  logic signed [W-1:0] out_score, out_score0;
  logic [2:0]          out_ptr, out_ptr0;

  int checks = 0;
  int errors = 0;
  logic [W+2:0] exp_q[$];  // {ptr, score}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  gap_cell_pipe #(.W(W), .G0(2), .GE(1), .DIR(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_m(in_m), .in_ixy(in_ixy), .in_iyz(in_iyz), .in_ixz(in_ixz),
    .in_ix(in_ix), .in_iy(in_iy), .in_iz(in_iz),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_ptr(out_ptr)
  );

  gap_cell_pipe #(.W(W), .G0(2), .GE(1), .DIR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_m(in_m), .in_ixy(in_ixy), .in_iyz(in_iyz), .in_ixz(in_ixz),
    .in_ix(in_ix), .in_iy(in_iy), .in_iz(in_iz),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_score(out_score0), .out_ptr(out_ptr0)
  );

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic signed [W-1:0] m, ixy, iyz, ixz, ix, iy, iz);
    in_m = m; in_ixy = ixy; in_iyz = iyz; in_ixz = ixz;
    in_ix = ix; in_iy = iy; in_iz = iz;
  endtask

  // Called at a falling edge with the pipe able to accept; returns one
  // falling edge later, after the bundle was taken on the rising edge.
  task automatic fire_one();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Backpressure bundle i: even -> m only (pen 4, ptr 0); odd -> iz only (pen 3, ptr 6).
  task automatic load_bp(input int i, output logic [W+2:0] e);
    if (i % 2 == 0) begin
      set_in(12'(20 + 5 * i), NI, NI, NI, NI, NI, NI);
      e = {3'd0, 12'(16 + 5 * i)};
    end else begin
      set_in(NI, NI, NI, NI, NI, NI, 12'(30 + i));
      e = {3'd6, 12'(27 + i)};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(NI, NI, NI, NI, NI, NI, NI);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_valid0 !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", out_valid, out_valid0);
    end
    checks++;
    if (out_score !== NI || out_ptr !== 3'd0) begin
      errors++; $display("FAIL reset_out: got score %0d ptr %0d expected -2048 ptr 0", out_score, out_ptr);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    set_in(12'sd10, NI, NI, NI, NI, NI, NI);
    fire_one();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: out_valid %b before 3 cycles, expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_score !== 12'sd6 || out_ptr !== 3'd0) begin
      errors++; $display("FAIL basic: got v=%b score %0d ptr %0d expected v=1 6 ptr 0", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    set_in(12'sd7, NI, NI, NI, NI, 12'sd5, NI);
    fire_one();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_score !== 12'sd3 || out_ptr !== 3'd0) begin
      errors++; $display("FAIL tie_low: got v=%b score %0d ptr %0d expected v=1 3 ptr 0", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
    set_in(12'sd6, NI, NI, NI, NI, 12'sd5, NI);
    fire_one();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_score !== 12'sd3 || out_ptr !== 3'd5) begin
      errors++; $display("FAIL tie_iy: got v=%b score %0d ptr %0d expected v=1 3 ptr 5", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    set_in(-12'sd2046, -12'sd2046, -12'sd2046, -12'sd2046, -12'sd2046, -12'sd2046, -12'sd2046);
    fire_one();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_score !== NI || out_ptr !== 3'd0) begin
      errors++; $display("FAIL saturation: got v=%b score %0d ptr %0d expected v=1 -2048 ptr 0", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
  endtask

  task automatic test_dir0();
    set_in(NI, NI, 12'sd10, NI, 12'sd9, NI, NI);
    fire_one();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid0 !== 1'b1 || out_score0 !== 12'sd7 || out_ptr0 !== 3'd4) begin
      errors++; $display("FAIL dir0: got v=%b score %0d ptr %0d expected v=1 7 ptr 4", out_valid0, out_score0, out_ptr0);
    end
    // Same bundle in the y cell: iyz 10-3=7 beats ix 9-3=6.
    checks++;
    if (out_valid !== 1'b1 || out_score !== 12'sd7 || out_ptr !== 3'd2) begin
      errors++; $display("FAIL dir1_same: got v=%b score %0d ptr %0d expected v=1 7 ptr 2", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] e;
    logic         exp_v;
    int           got;
    exp_q.delete();
    got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_v = (i >= 3 && i <= 6);
      checks++;
      if (out_valid !== exp_v) begin
        errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, out_valid, exp_v);
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if ({out_ptr, out_score} !== e) begin
          errors++; $display("FAIL b2b_data: got ptr %0d score %0d expected ptr %0d score %0d", out_ptr, out_score, e[W+2:W], $signed(e[W-1:0]));
        end
      end
      if (i < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
        end
        if (i % 2 == 0) begin
          set_in(12'(100 + i), NI, NI, NI, NI, NI, NI);
          exp_q.push_back({3'd0, 12'(96 + i)});
        end else begin
          set_in(NI, NI, NI, NI, 12'(40 + i), NI, NI);
          exp_q.push_back({3'd4, 12'(37 + i)});
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 4 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: got %0d results expected 4", got);
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] e, held;
    logic         have_held, fire;
    int           idx, acc, got;
    exp_q.delete();
    idx = 0; acc = 0; got = 0; have_held = 1'b0; held = '0;
    out_ready = 1'b0;
    load_bp(0, e);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      if (cyc == 6) begin
        checks++;
        if (acc != 3) begin
          errors++; $display("FAIL bp_accepted: got %0d expected 3", acc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
      end
      out_ready = (cyc >= 6);
      #1;
      if (out_valid === 1'b1 && !out_ready) begin
        if (have_held) begin
          checks++;
          if ({out_ptr, out_score} !== held) begin
            errors++; $display("FAIL bp_stable: got ptr %0d score %0d expected ptr %0d score %0d", out_ptr, out_score, held[W+2:W], $signed(held[W-1:0]));
          end
        end else begin
          held = {out_ptr, out_score};
          have_held = 1'b1;
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected result ptr %0d score %0d expected none", out_ptr, out_score);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({out_ptr, out_score} !== e) begin
            errors++; $display("FAIL bp_order: got ptr %0d score %0d expected ptr %0d score %0d", out_ptr, out_score, e[W+2:W], $signed(e[W-1:0]));
          end
        end
      end
      fire = in_valid && in_ready;
      if (fire) begin
        load_bp(idx, e);
        exp_q.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
      if (fire) begin
        idx++;
        if (idx < 5) load_bp(idx, e);
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 5 || exp_q.size() != 0 || acc != 5) begin
      errors++; $display("FAIL bp_complete: got %0d results from %0d accepted expected 5/5", got, acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    int stray;
    out_ready = 1'b1;
    set_in(12'sd50, NI, NI, NI, NI, NI, NI);
    in_valid = 1'b1;
    @(negedge clk);
    set_in(12'sd60, NI, NI, NI, NI, NI, NI);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_score !== NI) begin
      errors++; $display("FAIL rst_mid: got v=%b score %0d expected v=0 -2048", out_valid, out_score);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL rst_stale: got %0d stale valid cycles expected 0", stray);
    end
    set_in(NI, NI, NI, NI, NI, 12'sd20, NI);
    fire_one();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_latency_early: got v=%b expected 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_score !== 12'sd18 || out_ptr !== 3'd5) begin
      errors++; $display("FAIL rst_after: got v=%b score %0d ptr %0d expected v=1 18 ptr 5", out_valid, out_score, out_ptr);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_dir0();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
